// File: rtl/wfg_drive_spi_mc.sv
// rtl/wfg_drive_spi_mc.sv - multi-channel SPI output driver with run-time word length, mode, bit order and CS polarity
// Each accepted sample is shifted out on one chip-select; config is latched per frame.
module wfg_drive_spi_mc #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int CS_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_en_i,
  input  logic              ctrl_cpol_i,
  input  logic              ctrl_cpha_i,
  input  logic              ctrl_lsbfirst_i,
  input  logic              ctrl_sspol_i,
  input  logic [7:0]        ctrl_clkdiv_i,
  input  logic [4:0]        ctrl_wordlen_i,
  input  logic [7:0]        ctrl_gap_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic [CS_W-1:0]   s_tdest_i,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  output logic              sclk_o,
  output logic              sdo_o,
  output logic [NUM_CS-1:0] cs_o,
  output logic              busy_o,
  output logic              dest_err_o
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam logic [4:0] WL_MAX = 5'(DATA_W - 1);

  state_t              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [4:0]          len_q;
  logic [4:0]          bit_q;
  logic [6:0]          edge_q;
  logic [7:0]          div_q;
  logic [7:0]          clkdiv_q;
  logic [7:0]          gap_q;
  logic                cpha_q;
  logic                lsb_q;
  logic                sspol_q;
  logic                sclk_q;
  logic                sdo_q;
  logic [NUM_CS-1:0]   cs_q;
  logic                tready_q;
  logic                busy_q;
  logic                err_q;

  logic [4:0]          wl_in;
  logic [4:0]          first_bit;
  logic [4:0]          next_bit;
  logic                dest_ok;
  logic [NUM_CS-1:0]   sel_oh;
  logic [6:0]          edge_n;
  logic [6:0]          last_edge;
  logic                shift_now;
  logic [7:0]          gap_cnt;

  always_comb begin
    wl_in     = (ctrl_wordlen_i > WL_MAX) ? WL_MAX : ctrl_wordlen_i;
    first_bit = ctrl_lsbfirst_i ? 5'd0 : wl_in;
    next_bit  = lsb_q ? bit_q + 5'd1 : bit_q - 5'd1;
    dest_ok   = int'(s_tdest_i) < NUM_CS;
    sel_oh    = NUM_CS'(1) << s_tdest_i;
    edge_n    = edge_q + 7'd1;
    last_edge = {1'b0, len_q, 1'b0} + 7'd2;
    // CPHA=1 moves data on leading (odd) edges; CPHA=0 on trailing edges but not the final one
    shift_now = cpha_q ? edge_n[0] : (~edge_n[0] && (edge_n != last_edge));
    gap_cnt   = (gap_q == 8'd0) ? 8'd0 : gap_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      len_q    <= '0;
      bit_q    <= '0;
      edge_q   <= '0;
      div_q    <= '0;
      clkdiv_q <= '0;
      gap_q    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sspol_q  <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= 1'b0;
      cs_q     <= '1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q   <= ctrl_cpol_i;
          cs_q     <= {NUM_CS{~ctrl_sspol_i}};
          sdo_q    <= 1'b0;
          busy_q   <= 1'b0;
          tready_q <= ctrl_en_i;
          if (s_tvalid_i && tready_q) begin
            if (!dest_ok) begin
              err_q <= 1'b1;
            end else begin
              state_q  <= LEAD;
              busy_q   <= 1'b1;
              tready_q <= 1'b0;
              cs_q     <= ctrl_sspol_i ? sel_oh : ~sel_oh;
              data_q   <= s_tdata_i;
              len_q    <= wl_in;
              clkdiv_q <= ctrl_clkdiv_i;
              gap_q    <= ctrl_gap_i;
              cpha_q   <= ctrl_cpha_i;
              lsb_q    <= ctrl_lsbfirst_i;
              sspol_q  <= ctrl_sspol_i;
              div_q    <= ctrl_clkdiv_i;
              edge_q   <= '0;
              sdo_q    <= ctrl_cpha_i ? 1'b0 : s_tdata_i[first_bit];
              bit_q    <= ctrl_cpha_i ? first_bit
                        : (ctrl_lsbfirst_i ? first_bit + 5'd1 : first_bit - 5'd1);
            end
          end
        end
        LEAD, SHIFT: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else if (state_q == SHIFT && edge_q == last_edge) begin
            state_q <= TRAIL;
            div_q   <= clkdiv_q;
          end else begin
            // LEAD expiry is the first sclk edge; SHIFT shares the same edge logic
            state_q <= SHIFT;
            edge_q  <= edge_n;
            sclk_q  <= ~sclk_q;
            div_q   <= clkdiv_q;
            if (shift_now) begin
              sdo_q <= data_q[bit_q];
              bit_q <= next_bit;
            end
          end
        end
        TRAIL: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else begin
            state_q <= GAP;
            cs_q    <= {NUM_CS{~sspol_q}};
            sdo_q   <= 1'b0;
            div_q   <= gap_cnt;
          end
        end
        GAP: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            tready_q <= ctrl_en_i;
            sclk_q   <= ctrl_cpol_i;
            cs_q     <= {NUM_CS{~ctrl_sspol_i}};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_tready_o = tready_q;
  assign sclk_o     = sclk_q;
  assign sdo_o      = sdo_q;
  assign cs_o       = cs_q;
  assign busy_o     = busy_q;
  assign dest_err_o = err_q;

endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// tb/tb_wfg_drive_spi_mc.sv - self-checking bench for wfg_drive_spi_mc
// A negedge monitor decodes frames from the pins; tasks compare them to a bit-order model.
module tb_wfg_drive_spi_mc;
  localparam int DATA_W = 32;
  localparam int NUM_CS = 3;
  localparam int CS_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_en_i = 1'b0, ctrl_cpol_i = 1'b0, ctrl_cpha_i = 1'b0, ctrl_lsbfirst_i = 1'b0, ctrl_sspol_i = 1'b0;
  logic [7:0] ctrl_clkdiv_i = '0, ctrl_gap_i = '0;
  logic [4:0] ctrl_wordlen_i = '0;
  logic [DATA_W-1:0] s_tdata_i = '0;
  logic [CS_W-1:0] s_tdest_i = '0;
  logic s_tvalid_i = 1'b0;
  logic s_tready_o, sclk_o, sdo_o, busy_o, dest_err_o;
  logic [NUM_CS-1:0] cs_o;

  wfg_drive_spi_mc #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .CS_W(CS_W)) dut (
    .clk(clk), .rst(rst), .ctrl_en_i(ctrl_en_i), .ctrl_cpol_i(ctrl_cpol_i), .ctrl_cpha_i(ctrl_cpha_i),
    .ctrl_lsbfirst_i(ctrl_lsbfirst_i), .ctrl_sspol_i(ctrl_sspol_i), .ctrl_clkdiv_i(ctrl_clkdiv_i),
    .ctrl_wordlen_i(ctrl_wordlen_i), .ctrl_gap_i(ctrl_gap_i), .s_tdata_i(s_tdata_i), .s_tdest_i(s_tdest_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .sclk_o(sclk_o), .sdo_o(sdo_o), .cs_o(cs_o),
    .busy_o(busy_o), .dest_err_o(dest_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit mon_cpol, mon_cpha, mon_sspol;
  int q_len[$], q_n[$], q_gap[$];
  logic [63:0] q_rx[$];
  logic [NUM_CS-1:0] q_cs[$];
  bit q_viol[$];
  bit in_frame = 0, in_gap = 0, f_viol;
  int f_len, f_n = 0, g;
  logic [63:0] f_rx;
  logic [NUM_CS-1:0] f_cs, act;
  logic prev_sclk;

  // Frames are recognised only while busy so idle polarity changes are not mistaken for CS activity
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0; in_gap = 0; f_n = 0;
    end else begin
      act = cs_o ^ {NUM_CS{~mon_sspol}};
      if (!busy_o) act = '0;
      if (act != '0) begin
        if (!in_frame) begin
          in_frame = 1; f_len = 0; f_cs = act; f_rx = '0; f_n = 0; f_viol = 0; in_gap = 0;
        end
        f_len++;
        if (act != f_cs || s_tready_o) f_viol = 1;
        if (sclk_o != prev_sclk && sclk_o == ~(mon_cpol ^ mon_cpha)) begin
          f_rx = (f_rx << 1) | 64'(sdo_o); f_n++;
        end
      end else begin
        if (in_frame) begin
          q_len.push_back(f_len); q_n.push_back(f_n); q_rx.push_back(f_rx);
          q_cs.push_back(f_cs); q_viol.push_back(f_viol);
          in_frame = 0; in_gap = 1; g = 0;
        end
        if (in_gap) begin
          if (busy_o) g++;
          else begin q_gap.push_back(g); in_gap = 0; end
        end
      end
    end
    prev_sclk = sclk_o;
  end

  function automatic logic [63:0] model_rx(input logic [31:0] d, input int wordlen, input bit lsb);
    logic [63:0] r = '0;
    int L = wordlen + 1;
    for (int k = 0; k < L; k++) r = (r << 1) | 64'(d[lsb ? k : L - 1 - k]);
    return r;
  endfunction

  task automatic set_cfg(input bit cpol, cpha, lsb, sspol, input int clkdiv, wordlen, gap);
    ctrl_cpol_i = cpol; ctrl_cpha_i = cpha; ctrl_lsbfirst_i = lsb; ctrl_sspol_i = sspol;
    ctrl_clkdiv_i = 8'(clkdiv); ctrl_wordlen_i = 5'(wordlen); ctrl_gap_i = 8'(gap);
    mon_cpol = cpol; mon_cpha = cpha; mon_sspol = sspol;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_mon;
    q_len.delete(); q_n.delete(); q_gap.delete(); q_rx.delete(); q_cs.delete(); q_viol.delete();
  endtask

  task automatic send(input logic [31:0] d, input int dest, output bit ok);
    @(negedge clk);
    s_tdata_i = d; s_tdest_i = CS_W'(dest); s_tvalid_i = 1'b1; ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (s_tready_o) begin @(posedge clk); #1; ok = 1; end
      else @(negedge clk);
    end
    s_tvalid_i = 1'b0;
  endtask

  task automatic wait_gaps(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (q_gap.size() >= n) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #12;
    n_tests++; if (cs_o !== 3'b111 || sclk_o !== 1'b0 || sdo_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_pins: cs=%b sclk=%b sdo=%b want 111 0 0", cs_o, sclk_o, sdo_o); end
    n_tests++; if (s_tready_o !== 1'b0 || busy_o !== 1'b0 || dest_err_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: tready=%b busy=%b err=%b want 0 0 0", s_tready_o, busy_o, dest_err_o); end
    ctrl_en_i = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_cfg(1, 0, 0, 0, 0, 7, 0);
    n_tests++; if (s_tready_o !== 1'b1 || sclk_o !== 1'b1 || cs_o !== 3'b111) begin n_fail++;
      $display("FAIL idle_after_reset: tready=%b sclk=%b cs=%b want 1 1 111", s_tready_o, sclk_o, cs_o); end
  endtask

  task automatic test_mode0;
    bit ok;
    set_cfg(0, 0, 0, 0, 0, 31, 0); clear_mon();
    send(32'd25094, 0, ok); wait_gaps(1, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mode0_done: got %0b want 1", ok); return; end
    n_tests++; if (q_len[0] !== 66) begin n_fail++; $display("FAIL mode0_cs_len: got %0d want 66", q_len[0]); end
    n_tests++; if (q_rx[0] !== 64'h6206) begin n_fail++; $display("FAIL mode0_data: got %h want 6206", q_rx[0]); end
    n_tests++; if (q_n[0] !== 32) begin n_fail++; $display("FAIL mode0_edges: got %0d want 32", q_n[0]); end
    n_tests++; if (q_cs[0] !== 3'b001 || q_viol[0] !== 1'b0) begin n_fail++;
      $display("FAIL mode0_cs: got %b viol %0b want 001 viol 0", q_cs[0], q_viol[0]); end
    n_tests++; if (q_gap[0] !== 1) begin n_fail++; $display("FAIL mode0_gap: got %0d want 1", q_gap[0]); end
  endtask

  task automatic test_lsb_first;
    bit ok;
    set_cfg(0, 0, 1, 0, 3, 15, 2); clear_mon();
    send(32'hFFFFA5C3, 2, ok); wait_gaps(1, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lsb_done: got %0b want 1", ok); return; end
    n_tests++; if (q_len[0] !== 136) begin n_fail++; $display("FAIL lsb_cs_len: got %0d want 136", q_len[0]); end
    n_tests++; if (q_rx[0] !== 64'hC3A5 || q_n[0] !== 16) begin n_fail++;
      $display("FAIL lsb_data: got %h/%0d want c3a5/16", q_rx[0], q_n[0]); end
    n_tests++; if (q_cs[0] !== 3'b100 || q_gap[0] !== 2) begin n_fail++;
      $display("FAIL lsb_cs_gap: got %b/%0d want 100/2", q_cs[0], q_gap[0]); end
  endtask

  task automatic test_cpol_cpha;
    bit ok;
    set_cfg(1, 1, 0, 1, 0, 7, 0); clear_mon();
    n_tests++; if (sclk_o !== 1'b1 || cs_o !== 3'b000) begin n_fail++;
      $display("FAIL mode3_idle: sclk=%b cs=%b want 1 000", sclk_o, cs_o); end
    send(32'h81, 1, ok); wait_gaps(1, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mode3_done: got %0b want 1", ok); return; end
    n_tests++; if (q_rx[0] !== 64'h81 || q_n[0] !== 8 || q_len[0] !== 18) begin n_fail++;
      $display("FAIL mode3_frame: got %h/%0d/%0d want 81/8/18", q_rx[0], q_n[0], q_len[0]); end
    n_tests++; if (q_cs[0] !== 3'b010 || q_viol[0] !== 1'b0) begin n_fail++;
      $display("FAIL mode3_cs: got %b viol %0b want 010 viol 0", q_cs[0], q_viol[0]); end
  endtask

  task automatic test_dest_err;
    bit ok;
    set_cfg(0, 0, 0, 0, 0, 7, 0); clear_mon();
    s_tdata_i = 32'h55; s_tdest_i = 2'd3; s_tvalid_i = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (dest_err_o !== 1'b1 || busy_o !== 1'b0 || s_tready_o !== 1'b1 || cs_o !== 3'b111) begin n_fail++;
      $display("FAIL dest_err_pulse: err=%b busy=%b tready=%b cs=%b want 1 0 1 111", dest_err_o, busy_o, s_tready_o, cs_o); end
    s_tdata_i = 32'hA7; s_tdest_i = 2'd0;
    @(posedge clk); #1;
    s_tvalid_i = 1'b0;
    n_tests++; if (dest_err_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++;
      $display("FAIL dest_err_next: err=%b busy=%b want 0 1", dest_err_o, busy_o); end
    wait_gaps(1, ok);
    n_tests++; if (ok !== 1'b1 || q_len.size() !== 1) begin n_fail++;
      $display("FAIL dest_err_frames: ok=%0b frames=%0d want 1 1", ok, q_len.size()); return; end
    n_tests++; if (q_rx[0] !== 64'hA7 || q_cs[0] !== 3'b001) begin n_fail++;
      $display("FAIL dest_err_data: got %h/%b want a7/001", q_rx[0], q_cs[0]); end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2, ok;
    set_cfg(0, 0, 0, 0, 0, 31, 5); clear_mon();
    send(32'd262134, 0, ok1); send(32'd10, 2, ok2); wait_gaps(2, ok);
    n_tests++; if ((ok1 & ok2 & ok) !== 1'b1) begin n_fail++;
      $display("FAIL b2b_done: got %0b%0b%0b want 111", ok1, ok2, ok); return; end
    n_tests++; if (q_rx[0] !== 64'd262134 || q_rx[1] !== 64'd10) begin n_fail++;
      $display("FAIL b2b_data: got %0d %0d want 262134 10", q_rx[0], q_rx[1]); end
    n_tests++; if (q_gap[0] !== 5 || q_gap[1] !== 5) begin n_fail++;
      $display("FAIL b2b_gap: got %0d %0d want 5 5", q_gap[0], q_gap[1]); end
    n_tests++; if (q_viol[0] !== 1'b0 || q_viol[1] !== 1'b0 || q_cs[1] !== 3'b100) begin n_fail++;
      $display("FAIL b2b_tready_cs: viol %0b%0b cs %b want 00 100", q_viol[0], q_viol[1], q_cs[1]); end
  endtask

  task automatic test_en_drop;
    bit ok;
    set_cfg(0, 1, 1, 0, 1, 11, 1); clear_mon();
    send(32'h0ABC, 1, ok);
    repeat (5) @(negedge clk);
    ctrl_en_i = 1'b0;
    wait_gaps(1, ok);
    n_tests++; if (ok !== 1'b1 || q_rx[0] !== model_rx(32'h0ABC, 11, 1)) begin n_fail++;
      $display("FAIL en_drop_frame: ok=%0b got %h want %h", ok, q_rx[0], model_rx(32'h0ABC, 11, 1)); end
    repeat (4) @(negedge clk);
    n_tests++; if (s_tready_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++;
      $display("FAIL en_drop_ready: tready=%b busy=%b want 0 0", s_tready_o, busy_o); end
    ctrl_en_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int i;
    set_cfg(0, 0, 0, 0, 1, 31, 0); clear_mon();
    send(32'hDEADBEEF, 1, ok);
    for (i = 0; i < 2000 && f_n < 10; i++) @(negedge clk);
    #2 rst = 1'b1; #1;
    n_tests++; if (i >= 2000 || cs_o !== 3'b111 || sclk_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid: cs=%b sclk=%b busy=%b want 111 0 0", cs_o, sclk_o, busy_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0; clear_mon();
    send(32'h13579BDF, 1, ok); wait_gaps(1, ok);
    n_tests++; if (ok !== 1'b1 || q_len.size() !== 1) begin n_fail++;
      $display("FAIL reset_resume_done: ok=%0b frames=%0d want 1 1", ok, q_len.size()); return; end
    n_tests++; if (q_rx[0] !== 64'h13579BDF || q_len[0] !== 132 || q_cs[0] !== 3'b010) begin n_fail++;
      $display("FAIL reset_resume: got %h/%0d/%b want 13579bdf/132/010", q_rx[0], q_len[0], q_cs[0]); end
  endtask

  task automatic test_random;
    bit ok, cpol, cpha, lsb, sspol;
    int div, wl, gap, dest, L, H;
    logic [31:0] d;
    for (int it = 0; it < 8; it++) begin
      cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom); sspol = 1'($urandom);
      div = $urandom_range(3, 0); gap = $urandom_range(3, 0); dest = $urandom_range(NUM_CS - 1, 0);
      wl = (it == 0) ? 0 : (it == 1) ? 31 : $urandom_range(31, 0);
      d = $urandom;
      L = wl + 1; H = div + 1;
      set_cfg(cpol, cpha, lsb, sspol, div, wl, gap); clear_mon();
      send(d, dest, ok);
      // mid-frame config changes must not disturb the frame in flight
      ctrl_cpha_i = 1'($urandom); ctrl_lsbfirst_i = 1'($urandom);
      ctrl_clkdiv_i = 8'($urandom_range(7, 0)); ctrl_wordlen_i = 5'($urandom); ctrl_gap_i = 8'($urandom_range(9, 0));
      wait_gaps(1, ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: got %0b want 1", it, ok); continue; end
      n_tests++; if (q_rx[0] !== model_rx(d, wl, lsb) || q_n[0] !== L) begin n_fail++;
        $display("FAIL rand%0d_data: got %h/%0d want %h/%0d", it, q_rx[0], q_n[0], model_rx(d, wl, lsb), L); end
      n_tests++; if (q_len[0] !== (2 * L + 2) * H) begin n_fail++;
        $display("FAIL rand%0d_cs_len: got %0d want %0d", it, q_len[0], (2 * L + 2) * H); end
      n_tests++; if (q_cs[0] !== NUM_CS'(1 << dest) || q_viol[0] !== 1'b0) begin n_fail++;
        $display("FAIL rand%0d_cs: got %b viol %0b want %b viol 0", it, q_cs[0], q_viol[0], NUM_CS'(1 << dest)); end
      n_tests++; if (q_gap[0] !== ((gap == 0) ? 1 : gap)) begin n_fail++;
        $display("FAIL rand%0d_gap: got %0d want %0d", it, q_gap[0], (gap == 0) ? 1 : gap); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_lsb_first();
    test_cpol_cpha();
    test_dest_err();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/wfg_drive_spi_mc.md
Name: wfg_drive_spi_mc

Overview:
Parametrised multi-channel SPI output driver for the waveform generator. It takes samples over a valid/ready stream, each tagged with a destination channel. It serialises each sample to one of NUM_CS chip-selects on a shared sclk/sdo. Word length, SPI mode, bit order, CS polarity, clock divider and inter-frame gap are set at run time; the previous fixed 32-bit, mode-0, single-CS driver had none of these.

Parameters:
DATA_W, 32, stream data width and maximum word length (1..32)
NUM_CS, 4, number of chip-select outputs (1..16)
CS_W, 2, width of the destination tag, at least clog2(NUM_CS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ctrl_en_i  in  1  driver enable
ctrl_cpol_i  in  1  sclk idle level
ctrl_cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
ctrl_lsbfirst_i  in  1  1: bit 0 is sent first
ctrl_sspol_i  in  1  CS active level (0 = active-low)
ctrl_clkdiv_i  in  8  sclk half-period = ctrl_clkdiv_i+1 clk cycles
ctrl_wordlen_i  in  5  bits per frame minus 1, clamped to DATA_W-1
ctrl_gap_i  in  8  idle clk cycles after CS deassert; 0 is treated as 1
s_tdata_i  in  DATA_W  sample
s_tdest_i  in  CS_W  channel index
s_tvalid_i  in  1  sample valid
s_tready_o  out  1  sample accepted when s_tvalid_i and s_tready_o are both high
sclk_o  out  1  SPI clock
sdo_o  out  1  SPI data
cs_o  out  NUM_CS  chip selects
busy_o  out  1  high whenever the FSM is not in IDLE
dest_err_o  out  1  one-cycle pulse when a sample with an out-of-range destination is dropped

Behaviour:
- All outputs are registered.
- Reset (async) forces: state IDLE, sclk_o=0, sdo_o=0, cs_o=all ones, s_tready_o=0, busy_o=0, dest_err_o=0.
- A reset during a frame aborts it immediately with these values; no partial frame resumes.
- In IDLE after reset:
  - sclk_o=ctrl_cpol_i and cs_o={NUM_CS{~ctrl_sspol_i}}, updated on the next clk.
  - s_tready_o = ctrl_en_i and (state==IDLE).
- On accept, the driver latches data, tdest, and all ctrl_* values. Config changes during a frame take effect only on the next accept.
- If tdest >= NUM_CS: pulse dest_err_o in the next cycle, stay in IDLE, assert no CS. s_tready_o stays high.
- Define H = clkdiv+1 and L = wordlen+1. FSM states: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
- LEAD (H cycles, entered the cycle after accept):
  - cs_o[tdest] asserts; sclk_o stays at CPOL.
  - If CPHA=0, sdo_o presents the first bit.
- SHIFT (2L*H cycles): sclk_o toggles every H cycles, giving 2L edges.
  - CPHA=0: shift on trailing edges except the last.
  - CPHA=1: shift on leading edges; the first bit appears at the first leading edge.
  - Bit order: MSB first starts at bit L-1; LSB first starts at bit 0. Bits above L-1 are ignored.
- TRAIL (H cycles): sclk_o back at CPOL; CS still asserted.
- GAP (max(gap,1) cycles): all CS deasserted, sdo_o=0.
- CS active time is exactly (2L+2)*H cycles.
- Accept-to-accept minimum is 1 + (2L+2)*H + max(gap,1) + 1 cycles, since s_tready_o returns high on the first IDLE cycle.
- ctrl_en_i dropping mid-frame does not abort: the frame completes, then s_tready_o stays low.
- busy_o is high in every state except IDLE.

Test Plan:
1. Mode 0, MSB first, clkdiv=0, wordlen=31, sspol=0, gap=0, send 25094 to tdest=0 -> cs_o[0] low for 66 cycles. Deserialising sdo_o on rising sclk gives 0x00006206. 32 rising edges; cs_o[3:1] stay high.
2. LSB first, wordlen=15, clkdiv=3, send 0xFFFFA5C3 to tdest=2 -> 16 bits sent 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. sclk period is 8 clk cycles; cs_o[2] low for 136 cycles.
3. CPOL=1, CPHA=1, sspol=1, wordlen=7, send 0x81 to tdest=1 -> sclk idles high; cs_o[1] is active-high. Sampling sdo on rising (trailing) edges gives 0x81.
4. tdest=3 with NUM_CS=3, send 0x55 -> dest_err_o pulses once; no CS asserts; next sample is accepted the following cycle.
5. Two back-to-back samples 262134 then 10, gap=5 -> CS deasserted for exactly 5 cycles between frames. Both values are received; s_tready_o is low during both frames.
6. Assert rst at bit 10 of a 32-bit frame -> same cycle: cs_o=all ones, sclk_o=0. After release, the next sample transmits fully and correctly.
